// File: rtl/multicycle_control_if.sv
// Control-to-datapath bundle: instruction/flag inputs from the datapath and every
// stage enable/select driven by the controller, plus the controller's state for observation.
interface multicycle_control_if;
   logic [31:0] Instr;
   logic        Zero;
   logic        IR_LdEn;
   logic        PC_Sel;
   logic        PC_LdEn;
   logic        RF_WrEn;
   logic        RF_WrData_sel;
   logic        RF_B_sel;
   logic [1:0]  ImmExt;
   logic        ALU_Bin_sel;
   logic [3:0]  ALU_func;
   logic        MEM_WrEn;
   logic        ByteOp;
   logic        InstrDone;
   logic        Illegal;
   logic [2:0]  state;

   // Handshake-free bundle: the controller owns every enable/select, the datapath
   // owns Instr and Zero; all signals are level-valid for the current clock cycle.
   modport master (
      input  Instr, Zero,
      output IR_LdEn, PC_Sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel,
             ImmExt, ALU_Bin_sel, ALU_func, MEM_WrEn, ByteOp, InstrDone, Illegal, state
   );

   modport slave (
      output Instr, Zero,
      input  IR_LdEn, PC_Sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel,
             ImmExt, ALU_Bin_sel, ALU_func, MEM_WrEn, ByteOp, InstrDone, Illegal, state
   );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle processor control FSM: FETCH -> DECODE -> EXEC/BRANCH -> MEM -> WB,
// decoding only the opcode/func latched during FETCH.
module multicycle_control (
   input  logic                   Clk,
   input  logic                   Reset,
   multicycle_control_if.master   bus
);

   localparam logic [5:0] OP_R    = 6'b100000;
   localparam logic [5:0] OP_LI   = 6'b111000;
   localparam logic [5:0] OP_LUI  = 6'b111001;
   localparam logic [5:0] OP_ADDI = 6'b110000;
   localparam logic [5:0] OP_ANDI = 6'b110010;
   localparam logic [5:0] OP_ORI  = 6'b110011;
   localparam logic [5:0] OP_B    = 6'b111111;
   localparam logic [5:0] OP_BEQ  = 6'b000000;
   localparam logic [5:0] OP_BNE  = 6'b000001;
   localparam logic [5:0] OP_LB   = 6'b000011;
   localparam logic [5:0] OP_LW   = 6'b001111;
   localparam logic [5:0] OP_SB   = 6'b000111;
   localparam logic [5:0] OP_SW   = 6'b011111;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_BRANCH = 3'd5
   } state_t;

   state_t     state_q, state_d;
   logic [5:0] opc_q, func_q;

   logic func_ok, is_alu, is_load, is_store, is_branch;
   logic unused_instr;

   assign unused_instr = ^bus.Instr[25:6];
   assign bus.state    = state_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_FETCH;
         opc_q   <= '0;
         func_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_FETCH) begin
            opc_q  <= bus.Instr[31:26];
            func_q <= bus.Instr[5:0];
         end
      end
   end

   // Instruction class from the latched copy only; live Instr is never decoded.
   always_comb begin
      func_ok = 1'b0;
      case (func_q)
         6'b110000, 6'b110001, 6'b110010, 6'b110011, 6'b110100,
         6'b111000, 6'b111001, 6'b111010, 6'b111100, 6'b111101: func_ok = 1'b1;
         default: func_ok = 1'b0;
      endcase
   end

   assign is_alu    = ((opc_q == OP_R) && func_ok) || (opc_q == OP_ADDI) || (opc_q == OP_ANDI) ||
                      (opc_q == OP_ORI) || (opc_q == OP_LI) || (opc_q == OP_LUI);
   assign is_load   = (opc_q == OP_LW) || (opc_q == OP_LB);
   assign is_store  = (opc_q == OP_SW) || (opc_q == OP_SB);
   assign is_branch = (opc_q == OP_B) || (opc_q == OP_BEQ) || (opc_q == OP_BNE);

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            if (is_alu || is_load || is_store) state_d = S_EXEC;
            else if (is_branch)                state_d = S_BRANCH;
            else                               state_d = S_FETCH;
         end
         S_EXEC:   state_d = (is_load || is_store) ? S_MEM : S_WB;
         S_MEM:    state_d = is_load ? S_WB : S_FETCH;
         S_WB:     state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         default:  state_d = S_FETCH;
      endcase
   end

   always_comb begin
      bus.IR_LdEn       = 1'b0;
      bus.PC_Sel        = 1'b0;
      bus.PC_LdEn       = 1'b0;
      bus.RF_WrEn       = 1'b0;
      bus.RF_WrData_sel = 1'b0;
      bus.RF_B_sel      = 1'b0;
      bus.ImmExt        = 2'b00;
      bus.ALU_Bin_sel   = 1'b0;
      bus.ALU_func      = 4'b0000;
      bus.MEM_WrEn      = 1'b0;
      bus.ByteOp        = 1'b0;
      bus.InstrDone     = 1'b0;
      bus.Illegal       = 1'b0;
      // Reset masks everything so a mid-instruction reset never leaks a partial write.
      if (!Reset) begin
         if (state_q != S_FETCH) begin
            case (opc_q)
               OP_ADDI, OP_LI, OP_LW, OP_LB, OP_SW, OP_SB: bus.ALU_Bin_sel = 1'b1;
               OP_ANDI: begin
                  bus.ImmExt      = 2'b01;
                  bus.ALU_Bin_sel = 1'b1;
                  bus.ALU_func    = 4'b0010;
               end
               OP_ORI: begin
                  bus.ImmExt      = 2'b01;
                  bus.ALU_Bin_sel = 1'b1;
                  bus.ALU_func    = 4'b0011;
               end
               OP_LUI: begin
                  bus.ImmExt      = 2'b10;
                  bus.ALU_Bin_sel = 1'b1;
               end
               OP_B, OP_BEQ, OP_BNE: begin
                  bus.ImmExt   = 2'b11;
                  bus.RF_B_sel = 1'b1;
                  bus.ALU_func = 4'b0001;
               end
               OP_R: begin
                  if (func_ok) bus.ALU_func = func_q[3:0];
               end
               default: ;
            endcase
            if (is_store) bus.RF_B_sel = 1'b1;
            bus.ByteOp = (opc_q == OP_LB) || (opc_q == OP_SB);
         end
         case (state_q)
            S_FETCH:  bus.IR_LdEn = 1'b1;
            S_DECODE: begin
               if (!(is_alu || is_load || is_store || is_branch)) begin
                  bus.PC_LdEn   = 1'b1;
                  bus.InstrDone = 1'b1;
                  bus.Illegal   = 1'b1;
               end
            end
            S_MEM: begin
               if (is_store) begin
                  bus.MEM_WrEn  = 1'b1;
                  bus.PC_LdEn   = 1'b1;
                  bus.InstrDone = 1'b1;
               end
            end
            S_WB: begin
               bus.RF_WrEn       = 1'b1;
               bus.RF_WrData_sel = is_load;
               bus.PC_LdEn       = 1'b1;
               bus.InstrDone     = 1'b1;
            end
            S_BRANCH: begin
               bus.PC_LdEn   = 1'b1;
               bus.InstrDone = 1'b1;
               if (opc_q == OP_B)        bus.PC_Sel = 1'b1;
               else if (opc_q == OP_BEQ) bus.PC_Sel = bus.Zero;
               else                      bus.PC_Sel = ~bus.Zero;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control FSM for the processor datapath. Latches the opcode/func of the instruction presented by the instruction-fetch stage, then sequences fetch, decode, execute, memory and write-back over 3–5 cycles. It drives every stage's enables and selects, including the PC load and branch select of the fetch stage. It sits beside the datapath top level; datapath stages contain no control logic of their own.

## Interface
Parameters:
- none; opcode and ALU encodings below are fixed ISA constants.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge
- Reset  in  1  synchronous, active-high; sampled on the rising edge of Clk
- Instr  in  32  instruction from the fetch stage; opcode = Instr[31:26], func = Instr[5:0]
- Zero  in  1  ALU zero flag, valid in the BRANCH state
- IR_LdEn  out  1  load datapath instruction register
- PC_Sel  out  1  0: PC+4; 1: PC+4+immediate (branch)
- PC_LdEn  out  1  load PC
- RF_WrEn  out  1  register-file write enable
- RF_WrData_sel  out  1  0: ALU result; 1: memory data
- RF_B_sel  out  1  0: read rt (Instr[15:11]); 1: read rd (Instr[20:16])
- ImmExt  out  2  00: sign-extend; 01: zero-extend; 10: imm<<16; 11: sign-extend<<2
- ALU_Bin_sel  out  1  0: register B; 1: immediate
- ALU_func  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 not, 1000 sra, 1001 srl, 1010 sll, 1100 rol, 1101 ror
- MEM_WrEn  out  1  data-memory write enable
- ByteOp  out  1  1 for lb/sb
- InstrDone  out  1  one-cycle pulse in the last cycle of each instruction (same cycle as PC_LdEn)
- Illegal  out  1  one-cycle pulse when an undefined opcode/func is decoded

## Operation
- Opcodes: R-type 100000; li 111000; lui 111001; addi 110000; andi 110010; ori 110011; b 111111; beq 000000; bne 000001; lb 000011; lw 001111; sb 000111; sw 011111.
- R-type func must be one of 110000, 110001, 110010, 110011, 110100, 111000, 111001, 111010, 111100, 111101; ALU_func = func[3:0]. Any other func is illegal.
- Internal opcode/func registers load in FETCH, in the same cycle as IR_LdEn. Decode in all later states uses the latched copy, never live Instr.
- States and transitions:
  - FETCH: IR_LdEn=1 → DECODE.
  - DECODE: no enables. R-type, imm, li, lui, load or store → EXEC. b/beq/bne → BRANCH. Illegal → FETCH with PC_LdEn=1, PC_Sel=0, InstrDone=1, Illegal=1.
  - EXEC: ALU-class → WB. Load/store → MEM.
  - MEM: loads → WB. Stores assert MEM_WrEn=1, PC_LdEn=1, InstrDone=1 → FETCH.
  - WB: RF_WrEn=1, PC_LdEn=1, PC_Sel=0, InstrDone=1 → FETCH.
  - BRANCH: PC_LdEn=1, InstrDone=1 → FETCH. PC_Sel is 1 for b, Zero for beq, !Zero for bne.
- Selects are Moore functions of state and the latched opcode, held stable from DECODE through the final state:
  - addi, li, lw, lb, sw, sb: ImmExt=00, ALU_Bin_sel=1, ALU_func add.
  - andi/ori: ImmExt=01, ALU_Bin_sel=1, ALU_func and/or.
  - lui: ImmExt=10, ALU_Bin_sel=1, ALU_func add (ISA requires rs=r0 for li/lui).
  - Branches: ImmExt=11, RF_B_sel=1, ALU_Bin_sel=0, ALU_func sub.
  - Stores: RF_B_sel=1.
  - Loads: RF_WrData_sel=1 in WB.
  - Unlisted outputs are 0.

## Timing
- Reset is sampled on the rising edge of Clk: state ← FETCH and opcode/func registers ← 0.
- While Reset=1, IR_LdEn, PC_LdEn, RF_WrEn, MEM_WrEn, InstrDone and Illegal are forced 0 combinationally, and all other outputs read 0. This holds even in the cycle Reset rises mid-instruction, so no partial write reaches the RF, memory or PC.
- First cycle after Reset deasserts: FETCH, IR_LdEn=1.
- Latency in cycles, FETCH through final state inclusive:
  - ALU/imm: 4
  - load: 5
  - store: 4
  - branch: 3
  - illegal: 2
- Exactly one PC_LdEn pulse per instruction, always in the same cycle as InstrDone. Never more than one write enable active in any cycle.
- Zero is sampled combinationally in BRANCH only; its value in any other state is ignored.

## Test plan
- Reset held 2 cycles during the WB of an add: RF_WrEn and PC_LdEn stay 0 throughout. After release, first cycle shows IR_LdEn=1 and no other enable.
- R-type sub (func 110001) → FETCH, DECODE, EXEC, WB. ALU_func=0001 and ALU_Bin_sel=0; RF_WrEn=1 and PC_LdEn=1 only in cycle 4.
- lw then sw: lw takes 5 cycles with RF_WrData_sel=1 and RF_WrEn=1 in cycle 5. sw takes 4 cycles with MEM_WrEn=1 in cycle 4, RF_WrEn never asserted, RF_B_sel=1.
- beq with Zero=1 and bne with Zero=1: beq gives PC_Sel=1, bne gives PC_Sel=0, both with ImmExt=11 and PC_LdEn=1 in cycle 3. b gives PC_Sel=1 regardless of Zero.
- Opcode 101010, and R-type func 111111: each gives Illegal=1 and PC_LdEn=1, PC_Sel=0 in cycle 2. No RF or memory write occurs; the next cycle is FETCH.
- Change Instr mid-instruction (after FETCH): control outputs follow the latched opcode, not live Instr. The InstrDone count equals the number of instructions issued.
